// File: rtl/clic_irq_gate_if.sv
// clic_irq_gate_if
// Bundles the interrupt-conditioning signals between the interrupt sources
// or CLIC side (master) and the gate (slave).
//   irq_raw_i      raw interrupt lines, NUM_IRQ bits
//   cfg_trig_i     per-line trigger mode (0 level, 1 edge)
//   cfg_pol_i      per-line polarity (0 active-high, 1 active-low)
//   ack_valid_i    CLIC acknowledge strobe
//   ack_id_i       id of the acknowledged line
//   sw_set_valid_i software pending-set strobe
//   sw_set_id_i    id of the line to set
//   irq_pending_o  registered pending vector
//   any_pending_o  registered OR of the pending vector
//   id_err_o       one-cycle pulse on an out-of-range ack/set id
// NUM_IRQ must match the NUM_IRQ of the clic_irq_gate bound to it.
interface clic_irq_gate_if #(
  parameter int NUM_IRQ = 256
);
  localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [NUM_IRQ-1:0] irq_raw_i;
  logic [NUM_IRQ-1:0] cfg_trig_i;
  logic [NUM_IRQ-1:0] cfg_pol_i;
  logic               ack_valid_i;
  logic [IDW-1:0]     ack_id_i;
  logic               sw_set_valid_i;
  logic [IDW-1:0]     sw_set_id_i;
  logic [NUM_IRQ-1:0] irq_pending_o;
  logic               any_pending_o;
  logic               id_err_o;

  modport master (
    output irq_raw_i, cfg_trig_i, cfg_pol_i,
    output ack_valid_i, ack_id_i, sw_set_valid_i, sw_set_id_i,
    input  irq_pending_o, any_pending_o, id_err_o
  );

  modport slave (
    input  irq_raw_i, cfg_trig_i, cfg_pol_i,
    input  ack_valid_i, ack_id_i, sw_set_valid_i, sw_set_id_i,
    output irq_pending_o, any_pending_o, id_err_o
  );
endinterface

// File: rtl/clic_irq_gate.sv
// clic_irq_gate
// Conditions raw interrupt lines for the CLIC: polarity inversion, sampling,
// rising-edge detection, and a per-line pending latch (level or edge mode).
// Edge-mode pending is set by a detected edge or a software set, and cleared
// by the CLIC acknowledge; a set wins over a simultaneous clear.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   bus     clic_irq_gate_if.slave (raw lines, config, ack/sw_set strobes,
//           pending vector, any-pending flag, id error pulse)
// Build option: define CLIC_IRQ_GATE_SYNC_EN to replace the single sample
// flop with a SYNC_STAGES-deep synchronizer for asynchronous sources
// (raw-to-pending latency becomes SYNC_STAGES + 1 instead of 2).
module clic_irq_gate #(
  parameter int NUM_IRQ     = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  clic_irq_gate_if.slave  bus
);

  localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

`ifdef CLIC_IRQ_GATE_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  // Number of sample flops between the conditioned line and s_q.
  localparam int DEPTH = SYNC_ON ? SYNC_STAGES : 1;

  logic [NUM_IRQ-1:0] cond;
  logic [NUM_IRQ-1:0] sync_q [DEPTH];
  logic [NUM_IRQ-1:0] s_q;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] edge_det;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [DEPTH-1:0]   warm_q;
  logic               any_q;
  logic               id_err_q;
  logic               id_err_d;

  assign cond     = bus.irq_raw_i ^ bus.cfg_pol_i;
  assign s_q      = sync_q[DEPTH-1];
  assign edge_det = s_q & ~prev_q;

  // Sample / synchronizer chain; s_q is its last stage.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= cond;
      for (int k = 1; k < DEPTH; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // The sample chain restarts at 0 after reset, so s_q does not reflect the
  // real lines until DEPTH cycles have passed. warm_q keeps prev_q forced to
  // all-ones for exactly that long, so a line that is already asserted when
  // reset is released never looks like a fresh rising edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      warm_q <= '1;
      prev_q <= '1;
    end else begin
      warm_q <= warm_q << 1;
      prev_q <= warm_q[DEPTH-1] ? '1 : s_q;
    end
  end

  // Per-line pending next state. Out-of-range ids never match any line,
  // so an offending strobe only raises id_err.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_line
    logic set_hit;
    logic clr_hit;
    assign set_hit = edge_det[gi] |
                     (bus.sw_set_valid_i && (bus.sw_set_id_i == IDW'(gi)));
    assign clr_hit = bus.ack_valid_i && (bus.ack_id_i == IDW'(gi));
    always_comb begin
      pending_d[gi] = pending_q[gi];
      if (!bus.cfg_trig_i[gi]) begin
        pending_d[gi] = s_q[gi];
      end else if (set_hit) begin
        pending_d[gi] = 1'b1;
      end else if (clr_hit) begin
        pending_d[gi] = 1'b0;
      end
    end
  end

  // Extra bit keeps the compare exact when NUM_IRQ is a power of two.
  assign id_err_d = (bus.ack_valid_i &&
                     ({1'b0, bus.ack_id_i} >= (IDW+1)'(NUM_IRQ))) ||
                    (bus.sw_set_valid_i &&
                     ({1'b0, bus.sw_set_id_i} >= (IDW+1)'(NUM_IRQ)));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= '0;
      any_q     <= 1'b0;
      id_err_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      any_q     <= |pending_d;
      id_err_q  <= id_err_d;
    end
  end

  assign bus.irq_pending_o = pending_q;
  assign bus.any_pending_o = any_q;
  assign bus.id_err_o      = id_err_q;

endmodule

// File: tb/tb_clic_irq_gate.sv
module tb_clic_irq_gate;
  localparam int N   = 200;
  localparam int SYN = 2;
`ifdef CLIC_IRQ_GATE_SYNC_EN
  localparam int LAT = SYN + 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [N-1:0] exp_v;

  always #5 clk = ~clk;

  clic_irq_gate_if #(.NUM_IRQ(N)) bus ();

  clic_irq_gate #(.NUM_IRQ(N), .SYNC_STAGES(SYN)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    // Reset with all lines asserted, all edge mode, active-high.
    rst_n              = 1'b0;
    bus.irq_raw_i      = '1;
    bus.cfg_trig_i     = '1;
    bus.cfg_pol_i      = '0;
    bus.ack_valid_i    = 1'b0;
    bus.ack_id_i       = '0;
    bus.sw_set_valid_i = 1'b0;
    bus.sw_set_id_i    = '0;
    tick(3);
    chk("rst_pending", bus.irq_pending_o, '0);
    chk("rst_any", N'(bus.any_pending_o), '0);
    chk("rst_err", N'(bus.id_err_o), '0);
    $display("reset held: pending=%0h any=%0b", bus.irq_pending_o, bus.any_pending_o);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      chk("post_rst_pending", bus.irq_pending_o, '0);
      chk("post_rst_any", N'(bus.any_pending_o), '0);
    end
    $display("reset release with lines high: no pending for 10 cycles");

    // Drop every line; falling edges must not set anything.
    bus.irq_raw_i = '0;
    tick(3);
    chk("fall_no_set", bus.irq_pending_o, '0);

    // Concurrent edges on 30 and 31.
    bus.irq_raw_i[30] = 1'b1;
    bus.irq_raw_i[31] = 1'b1;
    tick(LAT - 1);
    chk("conc_early", bus.irq_pending_o, '0);
    tick(1);
    exp_v = '0; exp_v[30] = 1'b1; exp_v[31] = 1'b1;
    chk("conc_set", bus.irq_pending_o, exp_v);
    chk("conc_any", N'(bus.any_pending_o), N'(1));
    $display("concurrent edges 30/31: pending[31:30]=%b", bus.irq_pending_o[31:30]);

    // Ack on 30 in the same cycle a new edge on 30 is detected: set wins.
    bus.irq_raw_i[30] = 1'b0;
    tick(3);
    chk("hold_edge30", bus.irq_pending_o, exp_v);
    bus.irq_raw_i[30] = 1'b1;
    tick(LAT - 1);
    bus.ack_valid_i = 1'b1;
    bus.ack_id_i    = 8'd30;
    tick(1);
    bus.ack_valid_i = 1'b0;
    chk("ack_vs_edge", bus.irq_pending_o, exp_v);
    $display("ack 30 with coincident edge: pending[30]=%b", bus.irq_pending_o[30]);
    bus.ack_valid_i = 1'b1;
    tick(1);
    bus.ack_valid_i = 1'b0;
    exp_v[30] = 1'b0;
    chk("ack30_clear", bus.irq_pending_o, exp_v);
    bus.ack_valid_i = 1'b1;
    bus.ack_id_i    = 8'd31;
    tick(1);
    bus.ack_valid_i = 1'b0;
    chk("ack31_clear", bus.irq_pending_o, '0);
    chk("ack31_any", N'(bus.any_pending_o), '0);
    $display("acks 30,31: pending=%0h any=%0b", bus.irq_pending_o, bus.any_pending_o);

    // Level mode, active-low on line 5.
    bus.irq_raw_i[5]  = 1'b1;
    bus.cfg_pol_i[5]  = 1'b1;
    bus.cfg_trig_i[5] = 1'b0;
    tick(3);
    chk("lvl_idle", N'(bus.irq_pending_o[5]), '0);
    bus.irq_raw_i[5] = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick(1);
      chk("lvl_seq", N'(bus.irq_pending_o[5]), N'((t >= LAT) && (t <= LAT + 3)));
      $display("level line 5 cycle %0d: pending[5]=%b", t, bus.irq_pending_o[5]);
      if (t == 2) begin
        bus.ack_valid_i = 1'b1;
        bus.ack_id_i    = 8'd5;
      end
      if (t == 3) bus.ack_valid_i = 1'b0;
      if (t == 4) bus.irq_raw_i[5] = 1'b1;
    end

    // Software set of edge line 7.
    bus.sw_set_valid_i = 1'b1;
    bus.sw_set_id_i    = 8'd7;
    tick(1);
    bus.sw_set_valid_i = 1'b0;
    exp_v = '0; exp_v[7] = 1'b1;
    chk("swset7", bus.irq_pending_o, exp_v);
    $display("sw_set 7: pending=%0h", bus.irq_pending_o);

    // Out-of-range ack and sw_set ids.
    bus.ack_valid_i = 1'b1;
    bus.ack_id_i    = 8'd250;
    tick(1);
    bus.ack_valid_i = 1'b0;
    chk("err_ack_pulse", N'(bus.id_err_o), N'(1));
    chk("err_ack_noeff", bus.irq_pending_o, exp_v);
    tick(1);
    chk("err_ack_once", N'(bus.id_err_o), '0);
    $display("ack id 250: err pulse seen, pending=%0h", bus.irq_pending_o);
    bus.sw_set_valid_i = 1'b1;
    bus.sw_set_id_i    = 8'd210;
    tick(1);
    bus.sw_set_valid_i = 1'b0;
    chk("err_set_pulse", N'(bus.id_err_o), N'(1));
    chk("err_set_noeff", bus.irq_pending_o, exp_v);
    // Highest legal id: no error, ack of non-pending line is a no-op.
    bus.ack_valid_i = 1'b1;
    bus.ack_id_i    = 8'd199;
    tick(1);
    bus.ack_valid_i = 1'b0;
    chk("ack199_noerr", N'(bus.id_err_o), '0);
    chk("ack199_noop", bus.irq_pending_o, exp_v);
    bus.ack_valid_i = 1'b1;
    bus.ack_id_i    = 8'd7;
    tick(1);
    bus.ack_valid_i = 1'b0;
    chk("ack7_clear", bus.irq_pending_o, '0);
    $display("range checks done: pending=%0h", bus.irq_pending_o);

    // Reset mid-operation with three pending lines held high.
    bus.irq_raw_i[30] = 1'b0;
    bus.irq_raw_i[31] = 1'b0;
    tick(3);
    bus.irq_raw_i[30] = 1'b1;
    bus.irq_raw_i[31] = 1'b1;
    bus.irq_raw_i[40] = 1'b1;
    tick(LAT);
    exp_v = '0; exp_v[30] = 1'b1; exp_v[31] = 1'b1; exp_v[40] = 1'b1;
    chk("pre_rst3", bus.irq_pending_o, exp_v);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("midrst_pending", bus.irq_pending_o, '0);
    chk("midrst_any", N'(bus.any_pending_o), '0);
    chk("midrst_err", N'(bus.id_err_o), '0);
    for (int c = 0; c < 6; c++) begin
      tick(1);
      chk("midrst_hold", bus.irq_pending_o, '0);
    end
    $display("mid-op reset: pending=%0h any=%0b", bus.irq_pending_o, bus.any_pending_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
